// File: rtl/battle_dp_core.sv
// battle_dp_core: combatant HP, move-choice/accuracy LFSR, move table and hit/damage resolution.
// Define CRIT_HIT_EN to enable critical hits (lfsr[11:8] == 4'hF doubles damage, capped at 15).

module battle_dp_hp_lane #(
  parameter int unsigned MAX_HP = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apply_i,
  input  logic [3:0] dmg_i,
  output logic [3:0] hp_o,
  output logic       ko_o
);
  logic [3:0] hp_q, hp_d;

  // Saturating subtract: a KO'd combatant stays at 0.
  always_comb begin
    hp_d = hp_q;
    if (apply_i) hp_d = (hp_q > dmg_i) ? hp_q - dmg_i : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hp_q <= 4'(MAX_HP);
    else     hp_q <= hp_d;
  end

  assign hp_o = hp_q;
  assign ko_o = (hp_q == 4'd0);
endmodule

module battle_dp_core #(
  parameter int unsigned  MAX_HP    = 9,
  parameter logic [15:0]  LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       target,
  input  logic [1:0] p_move,
  input  logic       actr,
  input  logic       calc_dmg,
  input  logic       app_dmg,
  input  logic       rng_hold,
  output logic [3:0] p_hp,
  output logic [3:0] AI_hp,
  output logic [1:0] ai_move,
  output logic       hit,
  output logic [3:0] dmg,
  output logic       crit,
  output logic       p_ko,
  output logic       ai_ko
);
  localparam int unsigned NUM_LANES = 2;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef struct packed {
    logic [3:0] dmg;
    logic [3:0] acc;
  } move_t;

  function automatic move_t move_lut(input logic [1:0] mv);
    case (mv)
      2'd0:    return '{dmg: 4'd1, acc: 4'd15};
      2'd1:    return '{dmg: 4'd2, acc: 4'd12};
      2'd2:    return '{dmg: 4'd3, acc: 4'd8};
      default: return '{dmg: 4'd5, acc: 4'd4};
    endcase
  endfunction

  logic [15:0] lfsr_q, lfsr_d;
  logic        hit_q, hit_d;
  logic [3:0]  dmg_q, dmg_d;
  logic [1:0]  mv;
  move_t       ent;
  logic [3:0]  acc_rnd;
  logic        crit_hit;
  logic [3:0]  dmg_calc;

  always_comb begin
    lfsr_d = lfsr_q;
    if (!rng_hold) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign ai_move = lfsr_q[1:0];
  assign acc_rnd = lfsr_q[7:4];
  assign mv      = actr ? ai_move : p_move;
  assign ent     = move_lut(mv);

`ifdef CRIT_HIT_EN
  logic [4:0] dbl;
  logic       crit_q, crit_d;

  assign crit_hit = (lfsr_q[11:8] == 4'hF);
  assign dbl      = {ent.dmg, 1'b0};
  assign dmg_calc = crit_hit ? ((dbl > 5'd15) ? 4'd15 : dbl[3:0]) : ent.dmg;

  always_comb begin
    crit_d = crit_q;
    if (calc_dmg) crit_d = crit_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crit_q <= 1'b0;
    else     crit_q <= crit_d;
  end

  assign crit = crit_q;
`else
  assign crit_hit = 1'b0;
  assign dmg_calc = ent.dmg;
  assign crit     = crit_hit;
`endif

  // Apply reads hit_q/dmg_q (pre-edge), so a same-cycle calc only affects later applies.
  always_comb begin
    hit_d = hit_q;
    dmg_d = dmg_q;
    if (calc_dmg) begin
      hit_d = (ent.acc >= acc_rnd);
      dmg_d = dmg_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      dmg_q <= 4'd0;
    end else begin
      hit_q <= hit_d;
      dmg_q <= dmg_d;
    end
  end

  assign hit = hit_q;
  assign dmg = dmg_q;

  // Lane 0 = player, lane 1 = AI.
  logic [NUM_LANES-1:0][3:0] hp;
  logic [NUM_LANES-1:0]      ko;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    battle_dp_hp_lane #(.MAX_HP(MAX_HP)) u_hp (
      .clk     (clk),
      .rst     (rst),
      .apply_i (app_dmg && hit_q && (target == 1'(g))),
      .dmg_i   (dmg_q),
      .hp_o    (hp[g]),
      .ko_o    (ko[g])
    );
  end

  assign p_hp  = hp[0];
  assign AI_hp = hp[1];
  assign p_ko  = ko[0];
  assign ai_ko = ko[1];
endmodule

// File: tb/tb_battle_dp_core.sv
// Self-checking bench for battle_dp_core: directed scenarios plus random traffic against a reference model.
module tb_battle_dp_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       target = 1'b0;
  logic [1:0] p_move = 2'd0;
  logic       actr = 1'b0;
  logic       calc_dmg = 1'b0;
  logic       app_dmg = 1'b0;
  logic       rng_hold = 1'b1;
  logic [3:0] p_hp, AI_hp, dmg;
  logic [1:0] ai_move;
  logic       hit, crit, p_ko, ai_ko;

  int checks = 0;
  int failures = 0;

  battle_dp_core dut (
    .clk(clk), .rst(rst), .target(target), .p_move(p_move), .actr(actr),
    .calc_dmg(calc_dmg), .app_dmg(app_dmg), .rng_hold(rng_hold),
    .p_hp(p_hp), .AI_hp(AI_hp), .ai_move(ai_move), .hit(hit), .dmg(dmg),
    .crit(crit), .p_ko(p_ko), .ai_ko(ai_ko)
  );

  always #5 clk = ~clk;

  // Reference model
  int          DMG_T[4] = '{1, 2, 3, 5};
  int          ACC_T[4] = '{15, 12, 8, 4};
  logic [3:0]  m_php, m_aihp, m_dmg;
  logic        m_hit, m_crit;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_php = 4'd9; m_aihp = 4'd9; m_dmg = 4'd0; m_hit = 1'b0; m_crit = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    logic [15:0] l;
    int mv, nd;
    logic nh, nc;
    l = m_lfsr;
    if (app_dmg && m_hit) begin
      if (target) m_aihp = (m_aihp > m_dmg) ? m_aihp - m_dmg : 4'd0;
      else        m_php  = (m_php  > m_dmg) ? m_php  - m_dmg : 4'd0;
    end
    if (calc_dmg) begin
      mv = actr ? int'(l[1:0]) : int'(p_move);
      nh = (ACC_T[mv] >= int'(l[7:4]));
      nd = DMG_T[mv];
      nc = 1'b0;
`ifdef CRIT_HIT_EN
      if (l[11:8] == 4'hF) begin
        nc = 1'b1;
        nd = (2 * nd > 15) ? 15 : 2 * nd;
      end
`endif
      m_hit = nh; m_dmg = 4'(nd); m_crit = nc;
    end
    if (!rng_hold) m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  // Entered and left at a negedge; strobes are cleared.
  task automatic do_reset(input logic hold);
    #2 rst = 1'b1;
    calc_dmg = 1'b0; app_dmg = 1'b0; rng_hold = hold;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    p_move = 2'd0; actr = 1'b0; calc_dmg = 1'b1; tick();
    app_dmg = 1'b1; target = 1'b0; tick(); tick();
    calc_dmg = 1'b0; app_dmg = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (p_hp !== 4'd9) begin failures++; $display("FAIL reset_p_hp got=%0d exp=9", p_hp); end
    checks++; if (AI_hp !== 4'd9) begin failures++; $display("FAIL reset_ai_hp got=%0d exp=9", AI_hp); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b exp=0", hit); end
    checks++; if (dmg !== 4'd0) begin failures++; $display("FAIL reset_dmg got=%0d exp=0", dmg); end
    checks++; if (crit !== 1'b0) begin failures++; $display("FAIL reset_crit got=%0b exp=0", crit); end
    checks++; if (ai_move !== 2'b01) begin failures++; $display("FAIL reset_ai_move got=%0d exp=1", ai_move); end
    checks++; if (p_ko !== 1'b0 || ai_ko !== 1'b0) begin failures++; $display("FAIL reset_ko got=%0b%0b exp=00", p_ko, ai_ko); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hit_miss();
    do_reset(1'b1);
    actr = 1'b0; p_move = 2'd3; calc_dmg = 1'b1; tick(); calc_dmg = 1'b0;
    checks++; if (hit !== 1'b0 || dmg !== 4'd5) begin failures++; $display("FAIL mv3_calc got hit=%0b dmg=%0d exp hit=0 dmg=5", hit, dmg); end
    target = 1'b1; app_dmg = 1'b1; tick(); app_dmg = 1'b0;
    checks++; if (AI_hp !== 4'd9) begin failures++; $display("FAIL miss_no_dmg got=%0d exp=9", AI_hp); end
    p_move = 2'd1; calc_dmg = 1'b1; tick(); calc_dmg = 1'b0;
    checks++; if (hit !== 1'b0 || dmg !== 4'd2) begin failures++; $display("FAIL mv1_calc got hit=%0b dmg=%0d exp hit=0 dmg=2", hit, dmg); end
    p_move = 2'd0; calc_dmg = 1'b1; tick(); calc_dmg = 1'b0;
    checks++; if (hit !== 1'b1 || dmg !== 4'd1) begin failures++; $display("FAIL mv0_calc got hit=%0b dmg=%0d exp hit=1 dmg=1", hit, dmg); end
    target = 1'b1; app_dmg = 1'b1; tick(); app_dmg = 1'b0;
    checks++; if (AI_hp !== 4'd8 || p_hp !== 4'd9) begin failures++; $display("FAIL hit_apply got ai=%0d p=%0d exp ai=8 p=9", AI_hp, p_hp); end
    tick();
    checks++; if (AI_hp !== 4'd8 || hit !== 1'b1 || dmg !== 4'd1) begin failures++; $display("FAIL idle_hold got ai=%0d hit=%0b dmg=%0d", AI_hp, hit, dmg); end
  endtask

  task automatic test_ai_move();
    do_reset(1'b1);
    actr = 1'b1; p_move = 2'd0; calc_dmg = 1'b1; tick(); calc_dmg = 1'b0;
    checks++; if (dmg !== 4'd2 || hit !== 1'b0) begin failures++; $display("FAIL ai_move_calc got hit=%0b dmg=%0d exp hit=0 dmg=2", hit, dmg); end
    checks++; if (ai_move !== 2'd1) begin failures++; $display("FAIL ai_move_hold got=%0d exp=1", ai_move); end
    actr = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset(1'b1);
    actr = 1'b0; p_move = 2'd0; calc_dmg = 1'b1; tick(); calc_dmg = 1'b0;
    target = 1'b0; app_dmg = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (p_hp !== 4'(9 - k)) begin failures++; $display("FAIL sat_step%0d got=%0d exp=%0d", k, p_hp, 9 - k); end
    end
    checks++; if (p_ko !== 1'b1 || ai_ko !== 1'b0) begin failures++; $display("FAIL sat_ko got p=%0b ai=%0b exp p=1 ai=0", p_ko, ai_ko); end
    tick(); app_dmg = 1'b0;
    checks++; if (p_hp !== 4'd0 || AI_hp !== 4'd9) begin failures++; $display("FAIL sat_floor got p=%0d ai=%0d exp p=0 ai=9", p_hp, AI_hp); end
    checks++; if (hit !== 1'b1 || dmg !== 4'd1) begin failures++; $display("FAIL sat_latched got hit=%0b dmg=%0d exp 1/1", hit, dmg); end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b1);
    actr = 1'b0; p_move = 2'd0; calc_dmg = 1'b1; tick();
    p_move = 2'd3; target = 1'b1; app_dmg = 1'b1; tick();
    calc_dmg = 1'b0; app_dmg = 1'b0;
    checks++; if (AI_hp !== 4'd8) begin failures++; $display("FAIL simul_hp got=%0d exp=8", AI_hp); end
    checks++; if (dmg !== 4'd5 || hit !== 1'b0) begin failures++; $display("FAIL simul_latch got hit=%0b dmg=%0d exp hit=0 dmg=5", hit, dmg); end
    app_dmg = 1'b1; tick(); app_dmg = 1'b0;
    checks++; if (AI_hp !== 4'd8) begin failures++; $display("FAIL simul_miss_after got=%0d exp=8", AI_hp); end
  endtask

  task automatic test_lfsr_run();
    logic [1:0] frozen;
    do_reset(1'b0);
    for (int i = 0; i < 65535; i++) begin
      tick();
      checks++;
      if (ai_move !== m_lfsr[1:0]) begin
        failures++;
        if (failures < 20) $display("FAIL lfsr_seq step=%0d got=%0d exp=%0d", i, ai_move, m_lfsr[1:0]);
      end
    end
    checks++; if (ai_move !== 2'b01) begin failures++; $display("FAIL lfsr_period got=%0d exp=1", ai_move); end
    rng_hold = 1'b1;
    frozen = m_lfsr[1:0];
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ai_move !== frozen) begin failures++; $display("FAIL lfsr_hold got=%0d exp=%0d", ai_move, frozen); end
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      calc_dmg = ($urandom_range(0, 99) < 40);
      app_dmg  = ($urandom_range(0, 99) < 40);
      target   = 1'($urandom_range(0, 1));
      actr     = 1'($urandom_range(0, 1));
      p_move   = 2'($urandom_range(0, 3));
      rng_hold = ($urandom_range(0, 99) < 20);
      tick();
      checks++;
      if (p_hp !== m_php || AI_hp !== m_aihp || hit !== m_hit || dmg !== m_dmg ||
          crit !== m_crit || ai_move !== m_lfsr[1:0] ||
          p_ko !== (m_php == 4'd0) || ai_ko !== (m_aihp == 4'd0)) begin
        failures++;
        if (failures < 20)
          $display("FAIL rand_cyc%0d got p=%0d ai=%0d hit=%0b dmg=%0d crit=%0b mv=%0d exp p=%0d ai=%0d hit=%0b dmg=%0d crit=%0b mv=%0d",
                   i, p_hp, AI_hp, hit, dmg, crit, ai_move, m_php, m_aihp, m_hit, m_dmg, m_crit, m_lfsr[1:0]);
      end
    end
    calc_dmg = 1'b0; app_dmg = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_hit_miss();
    test_ai_move();
    test_saturation();
    test_simultaneous();
    test_lfsr_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
